// File: rtl/dmem_arbiter.sv
// Two-port Req/Ack arbiter in front of the data memory (P0 = CPU MEM stage, P1 = loader/debug).
// Build with DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed P0 priority.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          P0_Req,
  input  logic          P0_Write,
  input  logic [1:0]    P0_Size,
  input  logic [AW-1:0] P0_Addr,
  input  logic [DW-1:0] P0_WData,
  output logic          P0_Ack,
  output logic          P0_Err,
  output logic [DW-1:0] P0_RData,
  input  logic          P1_Req,
  input  logic          P1_Write,
  input  logic [1:0]    P1_Size,
  input  logic [AW-1:0] P1_Addr,
  input  logic [DW-1:0] P1_WData,
  output logic          P1_Ack,
  output logic          P1_Err,
  output logic [DW-1:0] P1_RData,
  output logic [AW-1:0] Mem_Address,
  output logic [DW-1:0] Mem_WriteData,
  output logic [1:0]    Mem_MemWrite,
  output logic [1:0]    Mem_MemRead,
  input  logic [DW-1:0] Mem_ReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          gnt;
  logic          win;
  logic          sel_write;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          illegal;

`ifdef DMEM_ARB_RR_EN
  logic pref;  // port that wins the next tie

  always_comb begin
    win = !P0_Req;
    if (P0_Req && P1_Req) win = pref;
  end
`else
  always_comb win = !P0_Req;
`endif

  always_comb begin
    sel_write = win ? P1_Write : P0_Write;
    sel_size  = win ? P1_Size  : P0_Size;
    sel_addr  = win ? P1_Addr  : P0_Addr;
    sel_wdata = win ? P1_WData : P0_WData;
    illegal   = (sel_size == 2'b00) ||
                (sel_size == 2'b01 && sel_addr[1:0] != 2'b00) ||
                (sel_size == 2'b10 && sel_addr[0]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      gnt           <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      pref          <= 1'b0;
`endif
      P0_Ack        <= 1'b0;
      P1_Ack        <= 1'b0;
      P0_Err        <= 1'b0;
      P1_Err        <= 1'b0;
      P0_RData      <= '0;
      P1_RData      <= '0;
      Mem_Address   <= '0;
      Mem_WriteData <= '0;
      Mem_MemWrite  <= 2'b00;
      Mem_MemRead   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (P0_Req || P1_Req) begin
            gnt <= win;
`ifdef DMEM_ARB_RR_EN
            pref <= ~win;
`endif
            if (illegal) begin
              // Rejected requests skip the memory entirely and answer next cycle.
              P0_Ack <= !win;
              P0_Err <= !win;
              P1_Ack <= win;
              P1_Err <= win;
              state  <= RESP;
            end else begin
              Mem_Address   <= sel_addr;
              Mem_WriteData <= sel_wdata;
              if (sel_write) Mem_MemWrite <= sel_size;
              else           Mem_MemRead  <= sel_size;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          Mem_MemWrite <= 2'b00;
          Mem_MemRead  <= 2'b00;
          if (Mem_MemRead != 2'b00) begin
            if (gnt) P1_RData <= Mem_ReadData;
            else     P0_RData <= Mem_ReadData;
          end
          P0_Ack <= !gnt;
          P1_Ack <= gnt;
          state  <= RESP;
        end
        RESP: begin
          P0_Ack <= 1'b0;
          P1_Ack <= 1'b0;
          P0_Err <= 1'b0;
          P1_Err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
